// File: rtl/time_bcd_conv_pkg.sv
// Shared types and constants for the toaster display BCD conversion path.
package toaster_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
  import toaster_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adj
);

  always_comb begin
    adj = digit;
    if (digit >= BCD_ADJ_THRESH) adj = digit + 4'd3;
  end

endmodule

// File: rtl/time_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// saturation to all-9s; the display result is held until the next complete conversion.
module time_bcd_conv
  import toaster_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned MAX   = 10**DIGITS - 1;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (BIN_W > 4 * DIGITS + 3) begin : g_width_check
    $error("time_bcd_conv: BIN_W too wide for DIGITS");
  end

  bcd_state_t         state, state_nxt;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[4*i +: 4]),
      .adj   (scratch_adj[4*i +: 4])
    );
  end

  // Saturation keeps the value below 10**DIGITS, so the adjusted top bit is always shifted out as 0.
  logic unused_adj_msb;
  assign unused_adj_msb = scratch_adj[BCD_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q   <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      busy    <= 1'b0;
      bcd_out <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (32'(bin_in) > MAX) begin
              bin_q <= BIN_W'(MAX);
              ovf_q <= 1'b1;
            end else begin
              bin_q <= bin_in;
              ovf_q <= 1'b0;
            end
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q   <= bin_q << 1;
          cnt     <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd_out <= scratch;
          ovf     <= ovf_q;
          valid   <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
